trap_filter_sequencer: RTL and testbench

// Acquisition sequencer for the trapezoidal shaping filter (parameters K, L, M in package_settings_V1).
// - Clears and enables the filter, then waits K+L samples for it to settle.
// - Triggers on a threshold crossing, tracks the flat-top peak, and reports amplitude + timestamp over valid/ready.
// - Sits between the filter output and the readout logic.

---
 rtl/trap_filter_sequencer_pkg.sv | 27 ++
 rtl/trap_filter_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_trap_filter_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_filter_sequencer_pkg.sv
// Shared types and sizing for the trapezoidal-filter acquisition sequencer.
// Filter geometry (K, L, M) and the derived settle/window lengths live here so
// the sequencer and any readout logic agree on them.
package pkg_trap_seq;

  localparam int SIZE_OUT_DATA = 16;
  localparam int SIZE_TS       = 16;
  localparam int K             = 5;
  localparam int L             = 8;
  localparam int M             = 16;

  localparam int SETTLE_LEN = K + L;
  localparam int WIN_LEN    = L - K + 1;
  localparam int CNT_W      = $clog2(((K + L) > M ? (K + L) : M) + 1);
  localparam int MISS_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    ARMED,
    PEAK,
    REPORT,
    HOLDOFF
  } seq_state_t;

endpackage

// File: rtl/trap_filter_sequencer.sv
// Acquisition sequencer for the trapezoidal shaping filter.
// Clears/enables the filter, waits for it to settle, triggers on a threshold
// crossing, tracks the flat-top peak and hands amplitude + timestamp to the
// readout over valid/ready. Triggers lost while reporting or in hold-off are
// counted in a saturating counter.
// Build option: define PILEUP_REJECT_EN to drop events whose flat top dips to
// or below threshold and rises above it again (pile-up); otherwise pileup is 0.
module trap_filter_sequencer
  import pkg_trap_seq::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            arm,
  input  logic signed [SIZE_OUT_DATA-1:0] thr,
  input  logic                            flt_valid,
  input  logic signed [SIZE_OUT_DATA-1:0] flt_data,
  output logic                            flt_en,
  output logic                            flt_clr,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic signed [SIZE_OUT_DATA-1:0] res_amp,
  output logic        [SIZE_TS-1:0]       res_ts,
  output logic                            busy,
  output logic                            pileup,
  output logic        [MISS_W-1:0]        miss_cnt
);

  // Last-sample values of the shared counter for each counting state.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(M - 1);

  seq_state_t                      state;
  logic        [CNT_W-1:0]         cnt;
  logic        [SIZE_TS-1:0]       ts;
  logic signed [SIZE_OUT_DATA-1:0] thr_q;
  logic signed [SIZE_OUT_DATA-1:0] peak;
  logic                            prev_le;
  logic                            above;
  logic                            crossing;

  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    return (v == {MISS_W{1'b1}}) ? v : v + MISS_W'(1);
  endfunction

  function automatic logic signed [SIZE_OUT_DATA-1:0] max_s(
    input logic signed [SIZE_OUT_DATA-1:0] a,
    input logic signed [SIZE_OUT_DATA-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  assign above    = flt_data > thr_q;
  assign crossing = flt_valid && above && prev_le;

  assign flt_en    = (state != IDLE);
  assign busy      = (state != IDLE);
  assign flt_clr   = (state == CLEAR);
  assign res_valid = (state == REPORT);
  assign res_amp   = peak;

  // Free-running sample timestamp; wraps naturally at 2^SIZE_TS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else if (flt_valid) ts <= ts + SIZE_TS'(1);
  end

  // Remember whether the previous sample sat at or below threshold, so a
  // crossing is an edge rather than a level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_le <= 1'b0;
    else if (flt_valid) prev_le <= !above;
  end

  // Count triggers that arrive while a result is pending or in hold-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) miss_cnt <= '0;
    else if (crossing && (state == REPORT || state == HOLDOFF)) miss_cnt <= sat_inc(miss_cnt);
  end

`ifdef PILEUP_REJECT_EN
  logic dipped;
  logic pileup_q;
  assign pileup = pileup_q;
`else
  assign pileup = 1'b0;
`endif

  // Sequencer: one shared counter serves settle, peak window and hold-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      thr_q  <= '0;
      peak   <= '0;
      res_ts <= '0;
`ifdef PILEUP_REJECT_EN
      dipped   <= 1'b0;
      pileup_q <= 1'b0;
`endif
    end else begin
`ifdef PILEUP_REJECT_EN
      pileup_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (arm) state <= CLEAR;
        end
        CLEAR: begin
          cnt   <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          if (flt_valid) begin
            if (cnt == SETTLE_LAST) begin
              cnt   <= '0;
              thr_q <= thr;
              state <= ARMED;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ARMED: begin
          if (!arm) begin
            state <= IDLE;
          end else if (flt_valid && above) begin
            res_ts <= ts;
            peak   <= flt_data;
            cnt    <= CNT_W'(1);
            state  <= (WIN_LEN == 1) ? REPORT : PEAK;
`ifdef PILEUP_REJECT_EN
            dipped <= 1'b0;
`endif
          end
        end
        PEAK: begin
          if (flt_valid) begin
`ifdef PILEUP_REJECT_EN
            // A second rise inside the flat top means two pulses overlapped.
            if (dipped && above) begin
              pileup_q <= 1'b1;
              cnt      <= '0;
              state    <= HOLDOFF;
            end else begin
              if (!above) dipped <= 1'b1;
`else
            begin
`endif
              peak <= max_s(peak, flt_data);
              cnt  <= cnt + CNT_W'(1);
              if (cnt == WIN_LAST) state <= REPORT;
            end
          end
        end
        REPORT: begin
          // A sample arriving with the accept is not part of hold-off.
          if (res_ready) begin
            cnt   <= '0;
            state <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (flt_valid) begin
            if (cnt == HOLD_LAST) begin
              cnt <= '0;
              if (arm) begin
                thr_q <= thr;
                state <= ARMED;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_filter_sequencer.sv
// Self-checking bench for trap_filter_sequencer with randomized sample values.
// Expected results come from sample-level bookkeeping: a running sample index
// for timestamps, the max of each window, and edge counting for lost triggers.
// Exercises the PILEUP_REJECT_EN branch when that macro is defined.
module tb_trap_filter_sequencer;

  localparam logic signed [15:0] THR = 16'sd100;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               arm;
  logic signed [15:0] thr;
  logic               flt_valid;
  logic signed [15:0] flt_data;
  logic               flt_en;
  logic               flt_clr;
  logic               res_valid;
  logic               res_ready;
  logic signed [15:0] res_amp;
  logic        [15:0] res_ts;
  logic               busy;
  logic               pileup;
  logic        [7:0]  miss_cnt;

  int n_pass  = 0;
  int n_total = 0;

  int  ts_model     = 0;
  int  miss_model   = 0;
  bit  count_misses = 1'b0;
  bit  prev_le_m    = 1'b0;
  logic signed [15:0] exp_amp;
  logic        [15:0] exp_ts;
  logic signed [15:0] win[$];

  trap_filter_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .thr       (thr),
    .flt_valid (flt_valid),
    .flt_data  (flt_data),
    .flt_en    (flt_en),
    .flt_clr   (flt_clr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_amp   (res_amp),
    .res_ts    (res_ts),
    .busy      (busy),
    .pileup    (pileup),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [15:0] rnd_hi();
    logic signed [15:0] v;
    v = 16'(101 + $urandom_range(899));
    return v;
  endfunction

  function automatic logic signed [15:0] rnd_lo();
    logic signed [15:0] v;
    v = 16'($urandom_range(600));
    return v - 16'sd500;
  endfunction

  function automatic logic signed [15:0] qmax(input logic signed [15:0] q[$]);
    logic signed [15:0] m;
    m = q[0];
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  // One filter sample; tracks sample index and lost-trigger edges.
  task automatic send(input logic signed [15:0] d);
    flt_valid = 1'b1;
    flt_data  = d;
    tick();
    flt_valid = 1'b0;
    if (count_misses && d > THR && prev_le_m && miss_model < 255) miss_model++;
    prev_le_m = (d <= THR);
    ts_model++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arm = 1'b0; thr = THR; flt_valid = 1'b0; flt_data = '0; res_ready = 1'b0;
    repeat (3) tick();
    n_total++; if (flt_en !== 1'b0) $display("FAIL reset_flt_en: got %0d expected 0", flt_en); else n_pass++;
    n_total++; if (flt_clr !== 1'b0) $display("FAIL reset_flt_clr: got %0d expected 0", flt_clr); else n_pass++;
    n_total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %0d expected 0", res_valid); else n_pass++;
    n_total++; if (res_amp !== 16'sd0) $display("FAIL reset_res_amp: got %0d expected 0", res_amp); else n_pass++;
    n_total++; if (res_ts !== 16'd0) $display("FAIL reset_res_ts: got %0d expected 0", res_ts); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0d expected 0", busy); else n_pass++;
    n_total++; if (pileup !== 1'b0) $display("FAIL reset_pileup: got %0d expected 0", pileup); else n_pass++;
    n_total++; if (miss_cnt !== 8'd0) $display("FAIL reset_miss_cnt: got %0d expected 0", miss_cnt); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL idle_unarmed_busy: got %0d expected 0", busy); else n_pass++;
    ts_model = 0; miss_model = 0; prev_le_m = 1'b0;
  endtask

  // Settle samples are all above threshold: any premature arming would trigger.
  task automatic test_settle();
    arm = 1'b1;
    tick();
    n_total++; if (flt_clr !== 1'b1) $display("FAIL settle_clr_pulse: got %0d expected 1", flt_clr); else n_pass++;
    n_total++; if (flt_en !== 1'b1) $display("FAIL settle_flt_en: got %0d expected 1", flt_en); else n_pass++;
    tick();
    n_total++; if (flt_clr !== 1'b0) $display("FAIL settle_clr_one_cycle: got %0d expected 0", flt_clr); else n_pass++;
    for (int i = 0; i < 13; i++) begin
      send(rnd_hi());
      n_total++; if (res_valid !== 1'b0) $display("FAIL settle_no_result_%0d: got %0d expected 0", i, res_valid); else n_pass++;
    end
  endtask

  task automatic test_peak();
    win = '{16'sd120, 16'sd340, 16'sd355, 16'sd350};
    exp_ts  = 16'(ts_model);
    exp_amp = qmax(win);
    for (int i = 0; i < 4; i++) begin
      send(win[i]);
      if (i < 3) begin
        n_total++; if (res_valid !== 1'b0) $display("FAIL peak_early_valid_%0d: got %0d expected 0", i, res_valid); else n_pass++;
      end
    end
    n_total++; if (res_valid !== 1'b1) $display("FAIL peak_res_valid: got %0d expected 1", res_valid); else n_pass++;
    n_total++; if (res_amp !== exp_amp) $display("FAIL peak_res_amp: got %0d expected %0d", res_amp, exp_amp); else n_pass++;
    n_total++; if (res_ts !== exp_ts) $display("FAIL peak_res_ts: got %0d expected %0d", res_ts, exp_ts); else n_pass++;
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    count_misses = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 3 || c == 9) send(rnd_lo());
      else if (c == 6 || c == 12) send(rnd_hi());
      else tick();
      n_total++; if (res_valid !== 1'b1) $display("FAIL bp_valid_c%0d: got %0d expected 1", c, res_valid); else n_pass++;
      n_total++; if (res_amp !== exp_amp) $display("FAIL bp_amp_c%0d: got %0d expected %0d", c, res_amp, exp_amp); else n_pass++;
      n_total++; if (res_ts !== exp_ts) $display("FAIL bp_ts_c%0d: got %0d expected %0d", c, res_ts, exp_ts); else n_pass++;
    end
    n_total++; if (miss_cnt !== 8'(miss_model)) $display("FAIL bp_miss_cnt: got %0d expected %0d", miss_cnt, miss_model); else n_pass++;
    // Accept together with a sample; that sample is not a hold-off sample.
    res_ready = 1'b1;
    send(rnd_lo());
    res_ready = 1'b0;
    n_total++; if (res_valid !== 1'b0) $display("FAIL bp_accept_valid: got %0d expected 0", res_valid); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL bp_accept_busy: got %0d expected 1", busy); else n_pass++;
  endtask

  task automatic test_holdoff();
    for (int i = 1; i <= 14; i++) send(rnd_lo());
    send(rnd_hi());
    send(rnd_hi());
    n_total++; if (res_valid !== 1'b0) $display("FAIL hold_no_result: got %0d expected 0", res_valid); else n_pass++;
    n_total++; if (miss_cnt !== 8'(miss_model)) $display("FAIL hold_miss_cnt: got %0d expected %0d", miss_cnt, miss_model); else n_pass++;
    count_misses = 1'b0;
    win = '{rnd_hi(), rnd_hi(), rnd_hi(), rnd_hi()};
    exp_ts  = 16'(ts_model);
    exp_amp = qmax(win);
    foreach (win[i]) send(win[i]);
    n_total++; if (res_valid !== 1'b1) $display("FAIL hold_trig_valid: got %0d expected 1", res_valid); else n_pass++;
    n_total++; if (res_amp !== exp_amp) $display("FAIL hold_trig_amp: got %0d expected %0d", res_amp, exp_amp); else n_pass++;
    n_total++; if (res_ts !== exp_ts) $display("FAIL hold_trig_ts: got %0d expected %0d", res_ts, exp_ts); else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_total++; if (res_valid !== 1'b0) $display("FAIL hold_accept_valid: got %0d expected 0", res_valid); else n_pass++;
  endtask

  task automatic test_arm_drop();
    count_misses = 1'b1;
    for (int i = 0; i < 16; i++) send(rnd_lo());
    count_misses = 1'b0;
    win = '{rnd_hi(), rnd_hi(), rnd_hi(), rnd_hi()};
    exp_ts  = 16'(ts_model);
    exp_amp = qmax(win);
    send(win[0]);
    arm = 1'b0;
    for (int i = 1; i < 4; i++) send(win[i]);
    n_total++; if (res_valid !== 1'b1) $display("FAIL armdrop_valid: got %0d expected 1", res_valid); else n_pass++;
    n_total++; if (res_amp !== exp_amp) $display("FAIL armdrop_amp: got %0d expected %0d", res_amp, exp_amp); else n_pass++;
    n_total++; if (res_ts !== exp_ts) $display("FAIL armdrop_ts: got %0d expected %0d", res_ts, exp_ts); else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(rnd_lo());
    n_total++; if (busy !== 1'b1) $display("FAIL armdrop_busy_holdoff: got %0d expected 1", busy); else n_pass++;
    send(rnd_lo());
    n_total++; if (busy !== 1'b0) $display("FAIL armdrop_busy_idle: got %0d expected 0", busy); else n_pass++;
    n_total++; if (flt_en !== 1'b0) $display("FAIL armdrop_flt_en: got %0d expected 0", flt_en); else n_pass++;
    n_total++; if (miss_cnt !== 8'(miss_model)) $display("FAIL armdrop_miss_cnt: got %0d expected %0d", miss_cnt, miss_model); else n_pass++;
  endtask

  task automatic rearm();
    arm = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 13; i++) send(rnd_lo());
  endtask

  task automatic test_reset_mid_peak();
    rearm();
    send(rnd_hi());
    send(rnd_hi());
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (flt_en !== 1'b0) $display("FAIL rstpeak_flt_en: got %0d expected 0", flt_en); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rstpeak_busy: got %0d expected 0", busy); else n_pass++;
    n_total++; if (res_valid !== 1'b0) $display("FAIL rstpeak_res_valid: got %0d expected 0", res_valid); else n_pass++;
    n_total++; if (res_amp !== 16'sd0) $display("FAIL rstpeak_res_amp: got %0d expected 0", res_amp); else n_pass++;
    n_total++; if (res_ts !== 16'd0) $display("FAIL rstpeak_res_ts: got %0d expected 0", res_ts); else n_pass++;
    n_total++; if (miss_cnt !== 8'd0) $display("FAIL rstpeak_miss_cnt: got %0d expected 0", miss_cnt); else n_pass++;
    arm = 1'b0;
    tick();
    rst_n = 1'b1;
    ts_model = 0; miss_model = 0; prev_le_m = 1'b0;
    tick();
  endtask

  task automatic test_pileup();
    rearm();
`ifdef PILEUP_REJECT_EN
    send(16'sd150);
    send(16'sd80);
    n_total++; if (pileup !== 1'b0) $display("FAIL pileup_before: got %0d expected 0", pileup); else n_pass++;
    send(16'sd150);
    n_total++; if (pileup !== 1'b1) $display("FAIL pileup_pulse: got %0d expected 1", pileup); else n_pass++;
    n_total++; if (res_valid !== 1'b0) $display("FAIL pileup_no_result: got %0d expected 0", res_valid); else n_pass++;
    tick();
    n_total++; if (pileup !== 1'b0) $display("FAIL pileup_one_cycle: got %0d expected 0", pileup); else n_pass++;
    n_total++; if (res_valid !== 1'b0) $display("FAIL pileup_still_no_result: got %0d expected 0", res_valid); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL pileup_holdoff_busy: got %0d expected 1", busy); else n_pass++;
`else
    win = '{16'sd150, 16'sd80, 16'sd150, rnd_hi()};
    exp_ts  = 16'(ts_model);
    exp_amp = qmax(win);
    foreach (win[i]) begin
      send(win[i]);
      n_total++; if (pileup !== 1'b0) $display("FAIL nopileup_tied_%0d: got %0d expected 0", i, pileup); else n_pass++;
    end
    n_total++; if (res_valid !== 1'b1) $display("FAIL nopileup_valid: got %0d expected 1", res_valid); else n_pass++;
    n_total++; if (res_amp !== exp_amp) $display("FAIL nopileup_amp: got %0d expected %0d", res_amp, exp_amp); else n_pass++;
    n_total++; if (res_ts !== exp_ts) $display("FAIL nopileup_ts: got %0d expected %0d", res_ts, exp_ts); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_settle();
    test_peak();
    test_backpressure();
    test_holdoff();
    test_arm_drop();
    test_reset_mid_peak();
    test_pileup();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
